// File: rtl/tl45_isa_pkg.sv
// TL45 ISA constants, instruction field positions and the decoded-instruction
// record shared by the decode stage and anything that checks it.
package tl45_isa_pkg;

   localparam logic [4:0] OP_NOP = 5'd0;
   localparam logic [4:0] OP_ADD = 5'd1;
   localparam logic [4:0] OP_SUB = 5'd2;
   localparam logic [4:0] OP_AND = 5'd3;
   localparam logic [4:0] OP_OR  = 5'd4;
   localparam logic [4:0] OP_XOR = 5'd5;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int IMM_BIT = 26;
   localparam int DR_MSB  = 25;
   localparam int DR_LSB  = 22;
   localparam int SR1_MSB = 21;
   localparam int SR1_LSB = 18;
   localparam int SR2_MSB = 17;
   localparam int SR2_LSB = 14;
   localparam int IMM_MSB = 15;

   typedef struct packed {
      logic [4:0]  opcode;
      logic        use_imm;
      logic [3:0]  dr;
      logic [3:0]  sr1;
      logic [3:0]  sr2;
      logic [31:0] imm32;
      logic        illegal;
   } decoded_t;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } dec_state_e;

   // Bitwise logic ops treat their immediate as an unsigned mask.
   function automatic logic is_zext_op(input logic [4:0] opcode);
      return (opcode == OP_AND) || (opcode == OP_OR) || (opcode == OP_XOR);
   endfunction

endpackage

// File: rtl/tl45_decode_if.sv
// Prefetch-to-decode-to-register-read bus. The decode stage sits on the slave
// modport; whoever feeds it (prefetch or a bench) sits on the master modport.
//
// Handshake: an instruction word is offered whenever i_buf_inst != 0 (zero is
// a bubble). Decode accepts it at a clock edge unless o_pipe_stall is high, in
// which case the source must hold the same word. o_valid marks a decoded
// instruction; downstream takes it on any edge where i_next_stall is low.
interface tl45_decode_if;
   import tl45_isa_pkg::*;

   logic [31:0] i_buf_pc;
   logic [31:0] i_buf_inst;
   logic        i_flush;
   logic        i_next_stall;
   logic        o_pipe_stall;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [4:0]  o_opcode;
   logic        o_use_imm;
   logic [3:0]  o_dr;
   logic [3:0]  o_sr1;
   logic [3:0]  o_sr2;
   logic [31:0] o_imm32;
   logic        o_illegal;
   dec_state_e  dbg_state;

   modport master (
      output i_buf_pc, i_buf_inst, i_flush, i_next_stall,
      input  o_pipe_stall, o_valid, o_pc, o_opcode, o_use_imm,
      input  o_dr, o_sr1, o_sr2, o_imm32, o_illegal, dbg_state
   );

   modport slave (
      input  i_buf_pc, i_buf_inst, i_flush, i_next_stall,
      output o_pipe_stall, o_valid, o_pc, o_opcode, o_use_imm,
      output o_dr, o_sr1, o_sr2, o_imm32, o_illegal, dbg_state
   );

endinterface

// File: rtl/tl45_decode_comb.sv
// Pure combinational instruction cracker: field split, immediate extension and
// opcode legality. Holds no state so it can be bound directly into properties.
module tl45_decode_comb
   import tl45_isa_pkg::*;
#(
   parameter int unsigned NUM_OPCODES = 16
) (
   input  logic [31:0] inst,
   output decoded_t    dec
);

   logic [4:0] opcode;

   assign opcode = inst[OPC_MSB:OPC_LSB];

   always_comb begin
      dec         = '0;
      dec.opcode  = opcode;
      dec.use_imm = inst[IMM_BIT];
      dec.dr      = inst[DR_MSB:DR_LSB];
      dec.sr1     = inst[SR1_MSB:SR1_LSB];
      // sr2 overlaps the immediate bits, so it is meaningless in immediate form.
      dec.sr2     = inst[IMM_BIT] ? 4'd0 : inst[SR2_MSB:SR2_LSB];
      dec.imm32   = is_zext_op(opcode) ? {16'h0000, inst[IMM_MSB:0]}
                                       : {{16{inst[IMM_MSB]}}, inst[IMM_MSB:0]};
      dec.illegal = ({27'd0, opcode} >= NUM_OPCODES);
   end

endmodule

// File: rtl/tl45_decode.sv
// TL45 decode stage: cracks the prefetch buffer word and holds the result in a
// stall-aware pipeline register; flush empties it and drops the current input.
module tl45_decode
   import tl45_isa_pkg::*;
#(
   parameter int unsigned NUM_OPCODES = 16
) (
   input  logic         i_clk,
   input  logic         i_reset,
   tl45_decode_if.slave bus
);

   dec_state_e  state_q, state_d;
   decoded_t    dec_q, dec_d;
   logic [31:0] pc_q, pc_d;
   decoded_t    dec_in;
   logic        in_valid;

   tl45_decode_comb #(.NUM_OPCODES(NUM_OPCODES)) u_comb (
      .inst (bus.i_buf_inst),
      .dec  (dec_in)
   );

   assign in_valid = (bus.i_buf_inst != 32'h0);

   always_comb begin
      state_d = state_q;
      dec_d   = dec_q;
      pc_d    = pc_q;
      if (bus.i_flush) begin
         state_d = ST_EMPTY;
         dec_d   = '0;
         pc_d    = '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_valid) begin
                  state_d = ST_FULL;
                  dec_d   = dec_in;
                  pc_d    = bus.i_buf_pc;
               end
            end
            ST_FULL: begin
               if (!bus.i_next_stall) begin
                  if (in_valid) begin
                     dec_d = dec_in;
                     pc_d  = bus.i_buf_pc;
                  end else begin
                     state_d = ST_EMPTY;
                     dec_d   = '0;
                     pc_d    = '0;
                  end
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_EMPTY;
         dec_q   <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         pc_q    <= pc_d;
      end
   end

   // A flush frees the register this edge, so prefetch must not be held.
   assign bus.o_pipe_stall = bus.o_valid && bus.i_next_stall && !bus.i_flush;

   assign bus.o_valid   = (state_q == ST_FULL);
   assign bus.o_pc      = pc_q;
   assign bus.o_opcode  = dec_q.opcode;
   assign bus.o_use_imm = dec_q.use_imm;
   assign bus.o_dr      = dec_q.dr;
   assign bus.o_sr1     = dec_q.sr1;
   assign bus.o_sr2     = dec_q.sr2;
   assign bus.o_imm32   = dec_q.imm32;
   assign bus.o_illegal = dec_q.illegal;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tl45_decode.sv
// Directed-vector bench for tl45_decode with hand-computed expectations.
module tb_tl45_decode;
   import tl45_isa_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] exp_q[$];

   tl45_decode_if dif();

   tl45_decode #(.NUM_OPCODES(16)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (dif)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                        input logic flush, input logic stall);
      dif.i_buf_pc     = pc;
      dif.i_buf_inst   = inst;
      dif.i_flush      = flush;
      dif.i_next_stall = stall;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_valid"}, 32'(dif.o_valid), 32'd0);
      check_val({tag, "_pc"}, dif.o_pc, 32'd0);
      check_val({tag, "_opcode"}, 32'(dif.o_opcode), 32'd0);
      check_val({tag, "_dr"}, 32'(dif.o_dr), 32'd0);
      check_val({tag, "_imm"}, dif.o_imm32, 32'd0);
      check_val({tag, "_illegal"}, 32'(dif.o_illegal), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      check_all_zero("reset");
      check_val("reset_stall", 32'(dif.o_pipe_stall), 32'd0);
      check_val("reset_state", 32'(dif.dbg_state), 32'(ST_EMPTY));
      rst = 1'b0;
      tick();
      check_val("bubble_valid", 32'(dif.o_valid), 32'd0);

      // basic register-form ADD
      drive(32'h100, 32'h0A48_FFFF, 1'b0, 1'b0);
      tick();
      check_val("add_valid", 32'(dif.o_valid), 32'd1);
      check_val("add_opcode", 32'(dif.o_opcode), 32'd1);
      check_val("add_use_imm", 32'(dif.o_use_imm), 32'd0);
      check_val("add_dr", 32'(dif.o_dr), 32'd9);
      check_val("add_sr1", 32'(dif.o_sr1), 32'd2);
      check_val("add_sr2", 32'(dif.o_sr2), 32'd3);
      check_val("add_imm", dif.o_imm32, 32'hFFFF_FFFF);
      check_val("add_pc", dif.o_pc, 32'h100);
      check_val("add_state", 32'(dif.dbg_state), 32'(ST_FULL));

      // AND immediate: zero-extended, sr2 forced to 0
      drive(32'h104, 32'h1C00_8000, 1'b0, 1'b0);
      tick();
      check_val("and_opcode", 32'(dif.o_opcode), 32'd3);
      check_val("and_use_imm", 32'(dif.o_use_imm), 32'd1);
      check_val("and_imm", dif.o_imm32, 32'h0000_8000);
      check_val("and_sr2", 32'(dif.o_sr2), 32'd0);
      check_val("and_pc", dif.o_pc, 32'h104);

      // stall for three cycles with changing input
      drive(32'h108, 32'h0A48_FFFF, 1'b0, 1'b1);
      #1;
      check_val("stall_pipe0", 32'(dif.o_pipe_stall), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("stall_pc", dif.o_pc, 32'h104);
         check_val("stall_imm", dif.o_imm32, 32'h0000_8000);
         check_val("stall_pipe", 32'(dif.o_pipe_stall), 32'd1);
         drive(32'h200 + 32'(i) * 4, 32'h0800_0010 + 32'(i), 1'b0, 1'b1);
      end
      drive(32'h300, 32'h0A48_FFFF, 1'b0, 1'b0);
      #1;
      check_val("release_pipe", 32'(dif.o_pipe_stall), 32'd0);
      tick();
      check_val("release_pc", dif.o_pc, 32'h300);
      check_val("release_opcode", 32'(dif.o_opcode), 32'd1);

      // flush beats stall and load
      drive(32'h400, 32'h1C00_8000, 1'b1, 1'b1);
      #1;
      check_val("flush_pipe", 32'(dif.o_pipe_stall), 32'd0);
      tick();
      check_all_zero("flush");
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      check_val("post_flush_valid", 32'(dif.o_valid), 32'd0);

      // opcode boundaries: NOP word, last legal, first illegal, max
      drive(32'h500, 32'h0000_0001, 1'b0, 1'b0);
      tick();
      check_val("nop_valid", 32'(dif.o_valid), 32'd1);
      check_val("nop_imm", dif.o_imm32, 32'd1);
      check_val("nop_illegal", 32'(dif.o_illegal), 32'd0);
      drive(32'h504, 32'h7800_0000, 1'b0, 1'b0);
      tick();
      check_val("op15_opcode", 32'(dif.o_opcode), 32'd15);
      check_val("op15_illegal", 32'(dif.o_illegal), 32'd0);
      drive(32'h508, 32'h8000_0000, 1'b0, 1'b0);
      tick();
      check_val("op16_illegal", 32'(dif.o_illegal), 32'd1);
      check_val("op16_imm", dif.o_imm32, 32'd0);
      drive(32'h50C, 32'hF800_0001, 1'b0, 1'b0);
      tick();
      check_val("op31_valid", 32'(dif.o_valid), 32'd1);
      check_val("op31_opcode", 32'(dif.o_opcode), 32'd31);
      check_val("op31_illegal", 32'(dif.o_illegal), 32'd1);
      check_val("op31_imm", dif.o_imm32, 32'd1);

      // back-to-back stream, one cycle lag on PC
      for (int i = 0; i < 6; i++) begin
         drive(32'h1000 + 32'(i) * 4, {5'd1, 27'(i + 1)}, 1'b0, 1'b0);
         exp_q.push_back(32'h1000 + 32'(i) * 4);
         tick();
         check_val("stream_valid", 32'(dif.o_valid), 32'd1);
         check_val("stream_pc", dif.o_pc, exp_q.pop_front());
         check_val("stream_imm", dif.o_imm32, 32'(i + 1));
      end
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      check_val("drain_valid", 32'(dif.o_valid), 32'd0);

      // asynchronous reset in the middle of a stall
      drive(32'h600, 32'h0A48_FFFF, 1'b0, 1'b0);
      tick();
      dif.i_next_stall = 1'b1;
      #1;
      check_val("pre_rst_pipe", 32'(dif.o_pipe_stall), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      check_val("mid_rst_pipe", 32'(dif.o_pipe_stall), 32'd0);
      tick();
      rst = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      check_val("after_rst_valid", 32'(dif.o_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl45_decode.md
Name: tl45_decode

Overview:
- Decode stage directly downstream of tl45_prefetch.
- Consumes the prefetch buffer (PC and instruction word, where an all-zero instruction word is a bubble).
- Splits the instruction into register indices, a 32-bit extended immediate and control flags, then holds them in a stall-aware pipeline register for the register-read stage.
- Back-pressures prefetch through o_pipe_stall and discards in-flight work on a flush from branch resolution.

Parameters:
- NUM_OPCODES, 16, opcodes 0..NUM_OPCODES-1 are legal; any higher opcode is flagged illegal.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-high reset
- i_buf_pc  in  32  PC from prefetch buffer
- i_buf_inst  in  32  instruction from prefetch buffer; 32'h0 = bubble
- i_flush  in  1  discard decode register and current input (branch taken / PC override)
- i_next_stall  in  1  downstream stage cannot accept this cycle
- o_pipe_stall  out  1  to prefetch i_pipe_stall; prefetch must hold its buffer
- o_valid  out  1  decode register holds a real instruction
- o_pc  out  32  PC of decoded instruction
- o_opcode  out  5  inst[31:27]
- o_use_imm  out  1  inst[26]; second operand is immediate
- o_dr  out  4  inst[25:22] destination register
- o_sr1  out  4  inst[21:18] source 1
- o_sr2  out  4  inst[17:14] source 2; forced to 0 when o_use_imm
- o_imm32  out  32  extended inst[15:0]
- o_illegal  out  1  opcode >= NUM_OPCODES

Behaviour:
- Reset (async, active-high): all outputs except o_pipe_stall are 0, o_valid=0; state=EMPTY. o_pipe_stall is combinational and evaluates to 0 during reset.
- Input valid: in_valid = (i_buf_inst != 0). A bubble never loads and never sets o_valid.
- States:
  - EMPTY (o_valid=0). Load on in_valid && !i_flush, then go to FULL.
  - FULL (o_valid=1). Three cases in order:
    - i_next_stall=1: hold all outputs unchanged.
    - i_next_stall=0 and in_valid: load the next instruction back-to-back and stay FULL.
    - i_next_stall=0 and bubble: clear to EMPTY.
- Latency: an instruction presented at edge N appears on the outputs after edge N (one cycle). Throughput is 1 instruction/cycle when unstalled.
- o_pipe_stall = o_valid && i_next_stall && !i_flush (combinational). Prefetch holds its buffer exactly while decode cannot accept.
- Flush:
  - i_flush=1 at an edge forces EMPTY and clears o_valid, o_illegal and all decoded fields to 0.
  - The input presented that cycle is dropped, even if valid.
  - Flush has priority over stall and over load.
- Immediate extension:
  - Opcodes 3, 4 and 5 (AND, OR, XOR) zero-extend inst[15:0].
  - All other opcodes sign-extend inst[15:0].
  - o_imm32 is computed regardless of o_use_imm.
- Illegal opcode:
  - Loads normally with o_valid=1 and o_illegal=1.
  - Fields are still extracted; the downstream stage raises the trap.
- Opcode 0 with a nonzero word is a legal NOP and loads as valid. Only the full 32'h0 word is a bubble.
- Reset mid-stall: outputs clear immediately and asynchronously; o_pipe_stall drops in the same cycle.
- No internal PC arithmetic; o_pc is a registered copy of i_buf_pc.

Decomposition:
- Package tl45_isa_pkg:
  - opcode localparams (NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, ...);
  - instruction field bit positions;
  - decoded-instruction struct typedef (opcode, use_imm, dr, sr1, sr2, imm32, illegal).
- Sub-module tl45_decode_comb: purely combinational field extraction, immediate extension and legality check. It is reusable by formal properties.
- Top level holds the state register, valid bit and stall/flush logic.

Test Plan:
1. Reset asserted mid-cycle with o_valid=1 -> all outputs 0 and o_pipe_stall=0 before the next edge. After release, 32'h0 input keeps o_valid=0.
2. i_buf_inst=32'h0A48_FFFF (opcode 1, use_imm=0, dr 9, sr1 2, sr2 3), pc=32'h100 -> next cycle o_valid=1, o_opcode=1, o_dr=9, o_sr1=2, o_sr2=3, o_imm32=32'hFFFF_FFFF, o_pc=32'h100.
3. i_buf_inst=32'h1C00_8000 (opcode 3, use_imm=1) -> o_imm32=32'h0000_8000, o_sr2=0, o_use_imm=1.
4. FULL with i_next_stall=1 for 3 cycles while input changes -> outputs frozen and o_pipe_stall=1 throughout. Stall release with new valid input -> new instruction loads next edge and o_pipe_stall=0.
5. i_flush=1 together with i_next_stall=1 and a valid input -> o_valid=0 next cycle, o_pipe_stall=0 during the flush cycle, and the input is not captured.
6. i_buf_inst=32'hF800_0001 (opcode 31) -> o_valid=1, o_illegal=1. Back-to-back valid instructions at 1/cycle with no stall -> o_pc sequence matches input with 1-cycle lag.
